qadd_pipe: RTL and testbench

- Parametrised, pipelined successor to the combinational sign-magnitude fixed-point adder.
- Adds or subtracts two N-bit sign-magnitude Q-format operands.
  - Sign is the MSB; the magnitude is the remaining N-1 bits.
- Two register stages, valid/ready handshake with backpressure, overflow flag, and canonical zero.
- Sits between fixed-point datapath producers and consumers (filters, accumulators) that need streaming throughput of one operation per clock.

---
 rtl/qadd_pipe.sv | 107 ++++++++++
 tb/tb_qadd_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/qadd_pipe.sv
// qadd_pipe: two-stage pipelined sign-magnitude fixed-point adder/subtractor
// with a valid/ready handshake, an overflow flag, and canonical (+0) zero.
// Q is documentation only. The arithmetic works on raw magnitudes.
// Optional macro QADD_PIPE_SAT_EN: on overflow, saturate the magnitude to
// all-ones instead of wrapping it.
module qadd_pipe #(
  parameter int N = 32,
  parameter int Q = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf
);

  localparam int M = N - 1;

  logic         en;

  logic         s1_valid_q;
  logic         s1_sa_q,   s1_sa_d;
  logic         s1_sb_q,   s1_sb_d;
  logic         s1_ge_q,   s1_ge_d;
  logic [N-1:0] s1_sum_q,  s1_sum_d;
  logic [M-1:0] s1_diff_q, s1_diff_d;

  logic         out_valid_q;
  logic [N-1:0] c_q,   c_d;
  logic         ovf_q, ovf_d;

  logic [M-1:0] ma, mb;
  logic [M-1:0] mag;
  logic         sign;

  // The whole pipe advances unless a valid result is waiting on downstream.
  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign ovf       = ovf_q;

  // Stage 1: split the operands and precompute the sum, |difference| and compare.
  always_comb begin
    ma        = a[M-1:0];
    mb        = b[M-1:0];
    s1_sa_d   = a[N-1];
    s1_sb_d   = b[N-1] ^ sub;
    s1_ge_d   = (ma >= mb);
    s1_sum_d  = {1'b0, ma} + {1'b0, mb};
    s1_diff_d = s1_ge_d ? (ma - mb) : (mb - ma);
  end

  // Stage 2: choose the magnitude and sign, handle overflow, and normalise zero.
  always_comb begin
    mag   = s1_sum_q[M-1:0];
    sign  = s1_sa_q;
    ovf_d = 1'b0;
    if (s1_sa_q == s1_sb_q) begin
      ovf_d = s1_sum_q[M];
`ifdef QADD_PIPE_SAT_EN
      if (ovf_d) begin
        mag = '1;
      end
`endif
    end else begin
      mag  = s1_diff_q;
      sign = s1_ge_q ? s1_sa_q : s1_sb_q;
    end
    if (mag == '0) begin
      sign = 1'b0;
    end
    c_d = {sign, mag};
  end

  // Pipeline registers: clear on reset, load together on en, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sa_q     <= 1'b0;
      s1_sb_q     <= 1'b0;
      s1_ge_q     <= 1'b0;
      s1_sum_q    <= '0;
      s1_diff_q   <= '0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      ovf_q       <= 1'b0;
    end else if (en) begin
      s1_valid_q  <= in_valid;
      s1_sa_q     <= s1_sa_d;
      s1_sb_q     <= s1_sb_d;
      s1_ge_q     <= s1_ge_d;
      s1_sum_q    <= s1_sum_d;
      s1_diff_q   <= s1_diff_d;
      out_valid_q <= s1_valid_q;
      c_q         <= c_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_qadd_pipe.sv
// Scoreboard testbench for qadd_pipe (N=32). Inputs change 1 time unit after
// posedge. All sampling happens at negedge.
module tb_qadd_pipe;

  localparam int N = 32;
  localparam longint MAXM = (64'sd1 <<< (N - 1)) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [N-1:0] c;
  logic         ovf;

  int checks = 0;
  int passes = 0;

  logic [N:0] exp_q[$];

  logic         prev_stall = 1'b0;
  logic [N-1:0] prev_c;
  logic         prev_ovf;
  logic         rand_bp = 1'b0;
  logic         bp_win = 1'b0;
  logic         saw_block = 1'b0;

  qadd_pipe #(.N(N), .Q(15)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Reference: signed arithmetic on the represented values, then recoding.
  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                       input logic s);
    longint mx, my, vx, vy, r, mag;
    logic neg, of;
    mx  = longint'(x[N-2:0]);
    my  = longint'(y[N-2:0]);
    vx  = x[N-1] ? -mx : mx;
    vy  = (y[N-1] ^ s) ? -my : my;
    r   = vx + vy;
    neg = (r < 0);
    mag = neg ? -r : r;
    of  = (mag > MAXM);
    if (of) begin
`ifdef QADD_PIPE_SAT_EN
      mag = MAXM;
`else
      mag = mag - (MAXM + 1);
`endif
    end
    if (mag == 0) neg = 1'b0;
    return {neg, mag[N-2:0], of};
  endfunction

  // Monitor and scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
      if (bp_win && !in_ready) saw_block = 1'b1;
      if (prev_stall) begin
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_c", {32'd0, c}, {32'd0, prev_c});
        chk("stall_ovf", {63'd0, ovf}, {63'd0, prev_ovf});
      end
      prev_stall = out_valid && !out_ready;
      prev_c     = c;
      prev_ovf   = ovf;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", {32'd0, c}, 64'hDEAD);
        end else begin
          logic [N:0] e;
          e = exp_q.pop_front();
          chk("c", {32'd0, c}, {32'd0, e[N:1]});
          chk("ovf", {63'd0, ovf}, {63'd0, e[0]});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, sub));
    end
  end

  // Random backpressure while enabled.
  always @(posedge clk) begin
    if (rand_bp) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Called at posedge+1. Returns at the posedge+1 after the transfer, with in_valid still 1.
  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    int n;
    a = x; b = y; sub = s; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) chk("send_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] ra, rb;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_c", {32'd0, c}, 64'd0);
    chk("rst_ovf", {63'd0, ovf}, 64'd0);
    @(posedge clk); #1;

    // Two-cycle latency on the first operation.
    send(32'h0000C000, 32'h00002000, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat1_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("lat2_valid", {63'd0, out_valid}, 64'd1);
    chk("lat2_c", {32'd0, c}, 64'h0000E000);
    @(posedge clk); #1;

    // Directed vectors, sent back-to-back.
    send(32'h00002000, 32'h8000C000, 1'b0);
    send(32'h00008000, 32'h00008000, 1'b1);
    send(32'h80000000, 32'h00000000, 1'b0);
    send(32'h7FFFFFFF, 32'h00000001, 1'b0);
    send(32'hFFFFFFFF, 32'h00000001, 1'b1);
    send(32'h80000005, 32'h00000005, 1'b0);
    drain();

    // Backpressure: 5 ops, with out_ready low for 3 cycles mid-stream.
    bp_win = 1'b1;
    fork
      begin
        for (int i = 1; i <= 5; i++) send(32'(i) * 32'h8000, 32'h00008000, 1'b0);
        in_valid = 1'b0;
      end
      begin
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b1;
      end
    join
    drain();
    bp_win = 1'b0;
    chk("bp_in_ready_dropped", {63'd0, saw_block}, 64'd1);

    // Reset with 2 ops in flight.
    send(32'h00001000, 32'h00001000, 1'b0);
    send(32'h00002000, 32'h00001000, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_c", {32'd0, c}, 64'd0);
    chk("mid_rst_ovf", {63'd0, ovf}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    send(32'h00003000, 32'h80001000, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_lat1", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("post_rst_lat2", {63'd0, out_valid}, 64'd1);
    chk("post_rst_c", {32'd0, c}, 64'h00002000);
    @(posedge clk); #1;
    drain();

    // Random ops with random gaps and random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 400; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: begin ra[30:28] = 3'b111; rb[30:28] = 3'b111; end
        1: rb[30:0] = ra[30:0];
        2: begin ra[30:8] = '0; rb[30:8] = '0; end
        default: ;
      endcase
      send(ra, rb, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    in_valid = 1'b0;
    rand_bp = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
